// File: rtl/axi_req_arbiter_if.sv
// Bundle of signals between the two requesters, the arbiter and the AXI master.
// The arbiter sits on the slave modport; the driving side (requesters and
// master model) uses the master modport.
`timescale 1ns/1ps
interface axi_req_arbiter_if;
  // requester side
  logic [1:0]  req;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [15:0] req_len;
  logic [5:0]  req_size;
  logic [3:0]  req_burst;
  logic [63:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [1:0]  rd_valid;
  logic [31:0] rdata;
  logic        timeout_err;
  logic        busy;
  // AXI master side
  logic        wr_tx;
  logic        rd_tx;
  logic [31:0] wr_addr;
  logic [31:0] rd_addr;
  logic [7:0]  wr_len;
  logic [7:0]  rd_len;
  logic [2:0]  wr_size;
  logic [2:0]  rd_size;
  logic [1:0]  wr_burst;
  logic [1:0]  rd_burst;
  logic [31:0] wr_data;
  logic        wr_done;
  logic        rd_done;
  logic        rd_data_valid;
  logic [31:0] rd_data;

  modport slave (
    input  req, req_write, req_addr, req_len, req_size, req_burst, req_wdata,
    input  wr_done, rd_done, rd_data_valid, rd_data,
    output gnt, done, rd_valid, rdata, timeout_err, busy,
    output wr_tx, rd_tx, wr_addr, rd_addr, wr_len, rd_len, wr_size, rd_size,
    output wr_burst, rd_burst, wr_data
  );

  modport master (
    output req, req_write, req_addr, req_len, req_size, req_burst, req_wdata,
    output wr_done, rd_done, rd_data_valid, rd_data,
    input  gnt, done, rd_valid, rdata, timeout_err, busy,
    input  wr_tx, rd_tx, wr_addr, rd_addr, wr_len, rd_len, wr_size, rd_size,
    input  wr_burst, rd_burst, wr_data
  );
endinterface

// File: rtl/axi_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI master.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE, with a
// watchdog that forces completion after TIMEOUT cycles in WAIT.
`timescale 1ns/1ps
module axi_req_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  axi_req_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [10:0] TO_LIMIT = 11'(TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_gnt;
  logic        r_last;
  logic [10:0] r_cnt;
  logic        r_to;
  // holding registers for the granted request
  logic        r_write;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [31:0] r_wdata;

  logic        w_win;
  logic        w_start;
  logic        w_master_done;
  logic        w_timeout;
  logic [10:0] w_cnt_inc;
  logic        w_act;
  logic        w_wr_sel;
  logic        w_rd_sel;
  logic        w_rd_wait;

  // Round-robin pick: on contention the requester that was not served last wins
  always_comb begin
    w_win = bus.req[1];
    if (bus.req == 2'b11) w_win = ~r_last;
  end

  assign w_start       = (r_state == S_IDLE) && (bus.req != 2'b00);
  assign w_master_done = r_write ? bus.wr_done : bus.rd_done;
  assign w_cnt_inc     = r_cnt + 11'd1;

  // Next-state logic; a master done takes priority over the watchdog
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_master_done) begin
          w_state_nxt = S_DONE;
        end else if (w_cnt_inc == TO_LIMIT) begin
          w_state_nxt = S_DONE;
          w_timeout   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant, round-robin pointer, watchdog counter and timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt  <= 2'b00;
      r_last <= 1'b1;
      r_cnt  <= '0;
      r_to   <= 1'b0;
    end else begin
      r_to <= w_timeout;
      case (r_state)
        S_IDLE:  if (w_start) r_gnt <= w_win ? 2'b10 : 2'b01;
        S_ISSUE: r_cnt <= '0;
        S_WAIT:  r_cnt <= w_cnt_inc;
        S_DONE: begin
          r_gnt  <= 2'b00;
          r_last <= r_gnt[1];
        end
        default: r_gnt <= 2'b00;
      endcase
    end
  end

  // Capture the winner's fields once, in IDLE; outputs are gated by state so
  // these need no reset
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_write <= w_win ? bus.req_write[1]     : bus.req_write[0];
      r_addr  <= w_win ? bus.req_addr[63:32]  : bus.req_addr[31:0];
      r_len   <= w_win ? bus.req_len[15:8]    : bus.req_len[7:0];
      r_size  <= w_win ? bus.req_size[5:3]    : bus.req_size[2:0];
      r_burst <= w_win ? bus.req_burst[3:2]   : bus.req_burst[1:0];
      r_wdata <= w_win ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
    end
  end

  assign w_act     = (r_state != S_IDLE);
  assign w_wr_sel  = w_act && r_write;
  assign w_rd_sel  = w_act && !r_write;
  assign w_rd_wait = (r_state == S_WAIT) && !r_write;

  assign bus.gnt         = r_gnt;
  assign bus.busy        = w_act;
  assign bus.done        = (r_state == S_DONE) ? r_gnt : 2'b00;
  assign bus.timeout_err = (r_state == S_DONE) && r_to;
  assign bus.wr_tx       = (r_state == S_ISSUE) && r_write;
  assign bus.rd_tx       = (r_state == S_ISSUE) && !r_write;
  assign bus.rd_valid    = w_rd_wait ? (r_gnt & {2{bus.rd_data_valid}}) : 2'b00;
  assign bus.rdata       = w_rd_wait ? bus.rd_data : 32'd0;

  assign bus.wr_addr  = w_wr_sel ? r_addr  : 32'd0;
  assign bus.wr_len   = w_wr_sel ? r_len   : 8'd0;
  assign bus.wr_size  = w_wr_sel ? r_size  : 3'd0;
  assign bus.wr_burst = w_wr_sel ? r_burst : 2'd0;
  assign bus.wr_data  = w_wr_sel ? r_wdata : 32'd0;
  assign bus.rd_addr  = w_rd_sel ? r_addr  : 32'd0;
  assign bus.rd_len   = w_rd_sel ? r_len   : 8'd0;
  assign bus.rd_size  = w_rd_sel ? r_size  : 3'd0;
  assign bus.rd_burst = w_rd_sel ? r_burst : 2'd0;
endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: transaction-level reference model plus
// literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_axi_req_arbiter;
  localparam int TO = 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  axi_req_arbiter_if ifc();

  axi_req_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // m_age counts cycles since the grant became visible: 0 is the issue cycle,
  // k>=1 is the k-th cycle spent waiting on the master.
  bit          m_started = 0;
  bit          m_active  = 0;
  bit          m_finish  = 0;
  bit          m_to      = 0;
  bit          m_last    = 1;
  bit          m_write   = 0;
  int          m_g       = 0;
  int          m_age     = 0;
  logic [31:0] m_addr, m_wdata;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1; m_active = 0; m_finish = 0; m_to = 0; m_last = 1;
    end else if (!m_active) begin
      if (ifc.req != 2'b00) begin
        if (ifc.req == 2'b11) m_g = m_last ? 0 : 1;
        else                  m_g = ifc.req[1] ? 1 : 0;
        m_write = ifc.req_write[m_g];
        m_addr  = ifc.req_addr[32*m_g +: 32];
        m_len   = ifc.req_len[8*m_g +: 8];
        m_size  = ifc.req_size[3*m_g +: 3];
        m_burst = ifc.req_burst[2*m_g +: 2];
        m_wdata = ifc.req_wdata[32*m_g +: 32];
        m_active = 1; m_age = 0; m_finish = 0; m_to = 0;
      end
    end else if (m_finish) begin
      m_active = 0;
      m_last   = (m_g == 1);
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (m_write ? ifc.wr_done : ifc.rd_done) begin
      m_finish = 1;
    end else if (m_age == TO) begin
      m_finish = 1; m_to = 1;
    end else begin
      m_age++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [1:0]  eg, edn, erv;
    logic        ewait, eto, ewtx, ertx;
    logic [31:0] erd;
    logic [76:0] ewf;
    logic [44:0] erf;
    if (m_started) begin
      eg    = m_active ? (2'b01 << m_g) : 2'b00;
      ewait = m_active && !m_finish && (m_age >= 1);
      ewtx  = m_active && (m_age == 0) && m_write;
      ertx  = m_active && (m_age == 0) && !m_write;
      erv   = (ewait && !m_write && ifc.rd_data_valid) ? eg : 2'b00;
      erd   = (ewait && !m_write) ? ifc.rd_data : 32'd0;
      edn   = (m_active && m_finish) ? eg : 2'b00;
      eto   = m_active && m_finish && m_to;
      ewf   = (m_active && m_write) ? {m_addr, m_len, m_size, m_burst, m_wdata} : 77'd0;
      erf   = (m_active && !m_write) ? {m_addr, m_len, m_size, m_burst} : 45'd0;
      check("m_gnt", ifc.gnt, eg);
      check("m_busy", ifc.busy, m_active);
      check("m_done", ifc.done, edn);
      check("m_timeout_err", ifc.timeout_err, eto);
      check("m_wr_tx", ifc.wr_tx, ewtx);
      check("m_rd_tx", ifc.rd_tx, ertx);
      check("m_rd_valid", ifc.rd_valid, erv);
      check("m_rdata", ifc.rdata, erd);
      check("m_wr_fields", {ifc.wr_addr, ifc.wr_len, ifc.wr_size, ifc.wr_burst, ifc.wr_data}, ewf);
      check("m_rd_fields", {ifc.rd_addr, ifc.rd_len, ifc.rd_size, ifc.rd_burst}, erf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for a grant, check it, complete via master after dly cycles
  task automatic serve(input string tag, input logic [1:0] exp_gnt, input bit is_wr, input int dly);
    int n;
    n = 0;
    @(negedge clk);
    while (ifc.gnt == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_gnt"}, ifc.gnt, exp_gnt);
    check({tag, "_tx"}, is_wr ? ifc.wr_tx : ifc.rd_tx, 1'b1);
    repeat (dly) cyc();
    if (is_wr) ifc.wr_done = 1'b1;
    else       ifc.rd_done = 1'b1;
    cyc();
    ifc.wr_done = 1'b0;
    ifc.rd_done = 1'b0;
    @(negedge clk);
    check({tag, "_done"}, ifc.done, exp_gnt);
  endtask

  initial begin
    int n;
    total = 0; bad = 0;
    reset = 1'b1;
    ifc.req = '0; ifc.req_write = '0; ifc.req_addr = '0; ifc.req_len = '0;
    ifc.req_size = '0; ifc.req_burst = '0; ifc.req_wdata = '0;
    ifc.wr_done = 1'b0; ifc.rd_done = 1'b0; ifc.rd_data_valid = 1'b0; ifc.rd_data = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_gnt", ifc.gnt, 2'b00);
    check("rst_busy", ifc.busy, 1'b0);

    // single write from requester 0
    cyc();
    ifc.req = 2'b01; ifc.req_write = 2'b01;
    ifc.req_addr = 64'h0000_0000_0000_1000; ifc.req_len = 16'h0003;
    ifc.req_size = 6'o02; ifc.req_burst = 4'b0001; ifc.req_wdata = 64'h0000_0000_CAFE_0001;
    @(negedge clk);
    check("w1_idle_gnt", ifc.gnt, 2'b00);
    cyc();
    @(negedge clk);
    check("w1_gnt", ifc.gnt, 2'b01);
    check("w1_wr_tx", ifc.wr_tx, 1'b1);
    check("w1_wr_addr", ifc.wr_addr, 32'h1000);
    check("w1_wr_len", ifc.wr_len, 8'd3);
    check("w1_rd_addr", ifc.rd_addr, 32'd0);
    repeat (5) @(posedge clk);
    #2 ifc.wr_done = 1'b1;
    cyc();
    ifc.wr_done = 1'b0;
    @(negedge clk);
    check("w1_done", ifc.done, 2'b01);
    check("w1_done_gnt", ifc.gnt, 2'b01);
    cyc();
    ifc.req = 2'b00;
    @(negedge clk);
    check("w1_after_gnt", ifc.gnt, 2'b00);
    check("w1_after_done", ifc.done, 2'b00);

    // reset so requester 0 has priority again, then contention
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    ifc.req_write = 2'b10;
    ifc.req_addr = 64'h0000_3000_0000_2000;
    ifc.req = 2'b11;
    serve("rr0", 2'b01, 1'b0, 2);
    serve("rr1", 2'b10, 1'b1, 3);
    serve("rr2", 2'b01, 1'b0, 1);
    cyc();
    ifc.req = 2'b00;

    // read burst for requester 1, with a stray wr_done
    cyc();
    ifc.req = 2'b10; ifc.req_write = 2'b00;
    ifc.req_addr = 64'h0000_4000_0000_0000; ifc.req_len = 16'h0300;
    @(negedge clk);
    check("rb_idle_gnt", ifc.gnt, 2'b00);
    cyc();
    @(negedge clk);
    check("rb_gnt", ifc.gnt, 2'b10);
    check("rb_rd_tx", ifc.rd_tx, 1'b1);
    check("rb_rd_addr", ifc.rd_addr, 32'h4000);
    check("rb_rd_len", ifc.rd_len, 8'd3);
    check("rb_wr_addr", ifc.wr_addr, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      ifc.rd_data_valid = 1'b1;
      ifc.rd_data = 32'hA0 + 32'(k);
      @(negedge clk);
      check("rb_rd_valid", ifc.rd_valid, 2'b10);
      check("rb_rdata", ifc.rdata, 32'hA0 + 32'(k));
    end
    cyc();
    ifc.rd_data_valid = 1'b0; ifc.rd_data = '0;
    ifc.wr_done = 1'b1;
    @(negedge clk);
    check("stray_busy", ifc.busy, 1'b1);
    check("stray_rd_valid", ifc.rd_valid, 2'b00);
    cyc();
    ifc.wr_done = 1'b0;
    @(negedge clk);
    check("stray_done", ifc.done, 2'b00);
    check("stray_gnt", ifc.gnt, 2'b10);
    cyc();
    ifc.rd_done = 1'b1;
    cyc();
    ifc.rd_done = 1'b0;
    @(negedge clk);
    check("rb_done", ifc.done, 2'b10);
    cyc();
    ifc.req = 2'b00;

    // watchdog timeout on a write; req and fields change mid-transaction
    cyc();
    ifc.req = 2'b01; ifc.req_write = 2'b01;
    ifc.req_addr = 64'h0000_0000_0000_5000;
    cyc();
    @(negedge clk);
    check("to_gnt", ifc.gnt, 2'b01);
    cyc();
    ifc.req = 2'b00;
    ifc.req_addr = 64'h0000_0000_DEAD_0000;
    @(negedge clk);
    check("to_held_addr", ifc.wr_addr, 32'h5000);
    n = 1;
    while (ifc.done == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("to_wait_cycles", n, 9);
    check("to_done", ifc.done, 2'b01);
    check("to_err", ifc.timeout_err, 1'b1);
    cyc();
    @(negedge clk);
    check("to_err_clear", ifc.timeout_err, 1'b0);

    // reset while waiting, then a normal re-request
    cyc();
    ifc.req = 2'b01; ifc.req_write = 2'b01;
    ifc.req_addr = 64'h0000_0000_0000_6000;
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("rw_gnt", ifc.gnt, 2'b00);
    check("rw_busy", ifc.busy, 1'b0);
    check("rw_done", ifc.done, 2'b00);
    check("rw_wr_addr", ifc.wr_addr, 32'd0);
    serve("rw_again", 2'b01, 1'b1, 2);
    cyc();
    ifc.req = 2'b00;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/axi_req_arbiter.md
AXI_REQ_ARBITER -- requirements
Module: axi_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023, is the maximum number of cycles spent in WAIT before forced completion.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  2  per-requester request; bit i for requester i; held high until done[i].
REQ-005 req_write  in  2  per-requester direction; 1 = write, 0 = read.
REQ-006 req_addr  in  64  packed addresses; [32i+31:32i] for requester i.
REQ-007 req_len  in  16  packed burst lengths; [8i+7:8i].
REQ-008 req_size  in  6  packed sizes; [3i+2:3i].
REQ-009 req_burst  in  4  packed burst types; [2i+1:2i].
REQ-010 req_wdata  in  64  packed write data; [32i+31:32i].
REQ-011 gnt  out  2  one-hot grant; 00 when no transaction is held.
REQ-012 done  out  2  one-cycle completion pulse to the granted requester.
REQ-013 rd_valid  out  2  forwarded rd_data_valid, routed to the granted requester only.
REQ-014 rdata  out  32  forwarded read data, shared by both requesters.
REQ-015 timeout_err  out  1  one-cycle pulse coincident with a done pulse caused by timeout.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 wr_tx, rd_tx  out  1 each  start pulses to the AXI master.
REQ-018 wr_addr/rd_addr 32, wr_len/rd_len 8, wr_size/rd_size 3, wr_burst/rd_burst 2, wr_data 32  out  latched request fields to the master.
REQ-019 wr_done, rd_done, rd_data_valid  in  1 each; rd_data  in  32; all driven from the master.

Function
REQ-020 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE, encoded in 2 bits.
REQ-021 IDLE: if req != 00, the block SHALL select a winner, latch that requester's fields into holding registers, set gnt to its one-hot value and move to ISSUE on the next edge.
REQ-022 Arbitration SHALL be round-robin using a 1-bit last pointer: if both requests are high, the requester != last wins; if one request is high, that requester wins.
REQ-023 ISSUE: for exactly one cycle, the block SHALL assert wr_tx if the latched direction is write, or rd_tx if it is read, then move to WAIT.
REQ-024 wr_tx and rd_tx SHALL never be high together and SHALL be low outside ISSUE.
REQ-025 The wr_* fields (write) or rd_* fields (read) SHALL hold the latched values from ISSUE through DONE; the unused direction's fields SHALL be driven to 0.
REQ-026 WAIT, write: on wr_done = 1 the block SHALL go to DONE; rd_done SHALL be ignored.
REQ-027 WAIT, read: on rd_done = 1 the block SHALL go to DONE; wr_done SHALL be ignored.
REQ-028 WAIT, read: rd_valid[g] SHALL equal rd_data_valid combinationally and rdata SHALL equal rd_data, where g is the granted requester; the other rd_valid bit SHALL be 0.
REQ-029 rd_valid SHALL be 00 in every state other than WAIT, and during WAIT for a write.
REQ-030 An 11-bit timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-031 When the timeout counter equals TIMEOUT with no done seen, the block SHALL go to DONE and pulse timeout_err in the DONE cycle.
REQ-032 The block SHALL NOT abort the master on timeout.
REQ-033 DONE (one cycle): done[g] = 1 and gnt SHALL still be held; at the exit edge gnt clears, last <= g and the state returns to IDLE.
REQ-034 At least one IDLE cycle SHALL occur between transactions, which matches the master's END-state recovery.
REQ-035 Deasserting req mid-transaction SHALL have no effect; the transaction completes and done still pulses.
REQ-036 Request fields SHALL be sampled only in IDLE; later input changes SHALL be ignored.
REQ-037 Latency: req rises before edge N in IDLE -> gnt and tx pulse in cycle N+1; done pulses in the cycle after the master's done is sampled.

Reset
REQ-038 When reset = 1 at a clock edge, the block SHALL set state = IDLE, last = 1 (so requester 0 wins first), counter = 0, and all outputs = 0, including gnt, done, rd_valid, rdata, timeout_err, busy, wr_tx, rd_tx and all field outputs.
REQ-039 Reset mid-transaction SHALL abandon the transaction with no done pulse; requesters SHALL re-request.

Verification
REQ-040 Single write: req=01, req_write=01, addr0=0x1000, len0=3 -> gnt=01 and a 1-cycle wr_tx with wr_addr=0x1000, wr_len=3; wr_done 5 cycles later -> done=01 one cycle later, then gnt=00.
REQ-041 Simultaneous requests after reset: req=11 held -> requester 0 served first, then requester 1; with both still requesting, the next grant goes to requester 0 (strict alternation).
REQ-042 Read burst forwarding: req=10 read, len=3, four rd_data_valid beats of 0xA0..0xA3 -> rd_valid=10 on those four cycles with rdata matching; rd_valid[0] stays 0; done=10 after rd_done.
REQ-043 Stray done: during a read, wr_done pulses -> no state change; rd_done later completes normally.
REQ-044 Timeout: TIMEOUT=8, write issued, no wr_done -> DONE after 8 WAIT cycles with done=01 and timeout_err=1 in the same cycle.
REQ-045 Reset during WAIT -> next cycle all outputs 0, busy=0, no done pulse; a new req is granted normally.
